syn_co_dec: RTL

Direction decoder for the synchronous up/down counter: it watches a sampled counter value stream and recovers the direction bit that produced each step (`1` = increment, `0` = decrement). It also detects illegal steps, tracks lock status and counts errors. It sits at the receiving end of a counter link, e.g. behind a register slice or a slower sampling domain already brought onto `clk`. It turns the counter output back into the original `d` bit stream.

---
 rtl/syn_co_dec_if.sv | 25 ++
 rtl/syn_co_dec.sv | 115 +++++++++++
 2 files changed

// File: rtl/syn_co_dec_if.sv
// Counter-link bundle for the direction decoder: sampled counter stream in,
// recovered direction bits and link health out.
interface syn_co_dec_if #(
  parameter int WIDTH = 3,
  parameter int ERR_W = 8
) ();
  logic [WIDTH-1:0] q_in;
  logic             q_vld;
  logic             resync;
  logic             d_out;
  logic             d_vld;
  logic             step_err;
  logic             locked;
  logic [ERR_W-1:0] err_cnt;

  modport master (
    output q_in, q_vld, resync,
    input  d_out, d_vld, step_err, locked, err_cnt
  );

  modport slave (
    input  q_in, q_vld, resync,
    output d_out, d_vld, step_err, locked, err_cnt
  );
endinterface

// File: rtl/syn_co_dec.sv
// Direction decoder: recovers the up/down bit behind each step of a sampled
// counter value, flags illegal steps, tracks lock and counts errors.
module syn_co_dec #(
  parameter int WIDTH    = 3,
  parameter int LOCK_CNT = 2,
  parameter int ERR_W    = 8
) (
  input  logic         clk,
  input  logic         rst,
  syn_co_dec_if.slave  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACQ  = 2'd1;
  localparam logic [1:0] S_LOCK = 2'd2;

  logic [1:0]       state_q,    state_d;
  logic [WIDTH-1:0] ref_q,      ref_d;
  logic             ref_vld_q,  ref_vld_d;
  logic [3:0]       good_q,     good_d;
  logic             d_out_q,    d_out_d;
  logic             d_vld_q,    d_vld_d;
  logic             step_err_q, step_err_d;
  logic [ERR_W-1:0] err_cnt_q,  err_cnt_d;

  logic [WIDTH-1:0] diff;
  logic             step_up;
  logic             step_dn;
  logic [3:0]       good_inc;

  // Modular subtraction makes wrap-around steps (max->0, 0->max) legal.
  assign diff     = bus.q_in - ref_q;
  assign step_up  = (diff == WIDTH'(1));
  assign step_dn  = (diff == {WIDTH{1'b1}});
  assign good_inc = good_q + 4'd1;

  always_comb begin
    // NOTE: every target gets a default first so no path leaves a latch.
    state_d    = state_q;
    ref_d      = ref_q;
    ref_vld_d  = ref_vld_q;
    good_d     = good_q;
    d_out_d    = d_out_q;
    d_vld_d    = 1'b0;
    step_err_d = 1'b0;
    err_cnt_d  = err_cnt_q;

    if (bus.resync) begin
      good_d = 4'd0;
      if (bus.q_vld) begin
        ref_d     = bus.q_in;
        ref_vld_d = 1'b1;
        state_d   = S_ACQ;
      end else begin
        ref_vld_d = 1'b0;
        state_d   = S_IDLE;
      end
    end else if (bus.q_vld) begin
      ref_d     = bus.q_in;
      ref_vld_d = 1'b1;
      if (state_q == S_IDLE || !ref_vld_q) begin
        good_d  = 4'd0;
        state_d = S_ACQ;
      end else if (step_up || step_dn) begin
        if (state_q == S_LOCK) begin
          d_vld_d = 1'b1;
          d_out_d = step_up;
        end else begin
          good_d = good_inc;
          if (good_inc == 4'(LOCK_CNT)) begin
            state_d = S_LOCK;
            d_vld_d = 1'b1;
            d_out_d = step_up;
          end
        end
      end else begin
        step_err_d = 1'b1;
        good_d     = 4'd0;
        state_d    = S_ACQ;
        if (err_cnt_q != {ERR_W{1'b1}}) err_cnt_d = err_cnt_q + ERR_W'(1);
      end
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ref_q      <= '0;
      ref_vld_q  <= 1'b0;
      good_q     <= 4'd0;
      d_out_q    <= 1'b0;
      d_vld_q    <= 1'b0;
      step_err_q <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      ref_q      <= ref_d;
      ref_vld_q  <= ref_vld_d;
      good_q     <= good_d;
      d_out_q    <= d_out_d;
      d_vld_q    <= d_vld_d;
      step_err_q <= step_err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign bus.d_out    = d_out_q;
  assign bus.d_vld    = d_vld_q;
  assign bus.step_err = step_err_q;
  assign bus.locked   = (state_q == S_LOCK);
  assign bus.err_cnt  = err_cnt_q;

endmodule
